// File: rtl/morse_key_classifier.sv
// Morse key front end: synchronizes and debounces the raw key, times presses and gaps in
// Morse units, and emits one-cycle dot/dash/character_break/space/etx pulses for char_encoder.
module morse_key_classifier #(
    parameter int unsigned UNIT_CYCLES     = 1000,
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned DASH_MIN_UNITS  = 2,
    parameter int unsigned CHAR_GAP_UNITS  = 2,
    parameter int unsigned WORD_GAP_UNITS  = 5,
    parameter int unsigned ETX_UNITS       = 20
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key,
    output logic dot,
    output logic dash,
    output logic character_break,
    output logic space,
    output logic etx
);

    localparam int unsigned PW = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
    localparam int unsigned DW = (DEBOUNCE_CYCLES > 0) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;

    localparam logic [PW-1:0] PRESC_LAST = PW'(UNIT_CYCLES - 1);
    localparam logic [DW-1:0] DB_LAST    = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [4:0]    DASH_MIN   = 5'(DASH_MIN_UNITS);
    localparam logic [4:0]    CHAR_GAP   = 5'(CHAR_GAP_UNITS);
    localparam logic [4:0]    WORD_GAP   = 5'(WORD_GAP_UNITS);
    localparam logic [4:0]    ETX_LIMIT  = 5'(ETX_UNITS);
    localparam logic [4:0]    UNITS_MAX  = 5'd31;
    localparam logic [2:0]    SYM_MAX    = 3'd5;

    // Synchronizer
    logic key_meta;
    logic key_s;

    // Debouncer
    logic [DW-1:0] db_cnt_q;
    logic [DW-1:0] db_cnt_d;
    logic          key_db_q;
    logic          key_db_d;
    logic          key_db_prev_q;

    // Unit timer
    logic [PW-1:0] presc_q;
    logic [PW-1:0] presc_d;
    logic [4:0]    units_q;
    logic [4:0]    units_d;

    // Character tracking
    logic [2:0] sym_cnt_q;
    logic [2:0] sym_cnt_d;
    logic       word_open_q;
    logic       word_open_d;

    // Output pulse next-state
    logic dot_d;
    logic dash_d;
    logic char_break_d;
    logic space_d;
    logic etx_d;

    logic db_rise;
    logic db_fall;
    logic db_edge;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_meta <= 1'b0;
            key_s    <= 1'b0;
        end else begin
            key_meta <= key;
            key_s    <= key_meta;
        end
    end

    // A single agreeing cycle restarts the stability count.
    always_comb begin
        db_cnt_d = '0;
        key_db_d = key_db_q;
        if (key_s != key_db_q) begin
            if (db_cnt_q == DB_LAST) begin
                key_db_d = key_s;
            end else begin
                db_cnt_d = db_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db_cnt_q      <= '0;
            key_db_q      <= 1'b0;
            key_db_prev_q <= 1'b0;
        end else begin
            db_cnt_q      <= db_cnt_d;
            key_db_q      <= key_db_d;
            key_db_prev_q <= key_db_q;
        end
    end

    // The edge cycle is the first cycle with the new key_db value.
    assign db_rise = key_db_q & ~key_db_prev_q;
    assign db_fall = ~key_db_q & key_db_prev_q;
    assign db_edge = db_rise | db_fall;

    always_comb begin
        presc_d = presc_q;
        units_d = units_q;
        if (db_edge) begin
            presc_d = '0;
            units_d = '0;
        end else if (presc_q == PRESC_LAST) begin
            presc_d = '0;
            if (units_q != UNITS_MAX) begin
                units_d = units_q + 5'd1;
            end
        end else begin
            presc_d = presc_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
            units_q <= '0;
        end else begin
            presc_q <= presc_d;
            units_q <= units_d;
        end
    end

    // Classification; the edge/timeout branches are exclusive, so at most one pulse fires.
    always_comb begin
        dot_d        = 1'b0;
        dash_d       = 1'b0;
        char_break_d = 1'b0;
        space_d      = 1'b0;
        etx_d        = 1'b0;
        sym_cnt_d    = sym_cnt_q;
        word_open_d  = word_open_q;

        if (db_fall) begin
            if (units_q < DASH_MIN) begin
                dot_d = 1'b1;
            end else begin
                dash_d = 1'b1;
            end
            word_open_d = 1'b1;
            sym_cnt_d   = sym_cnt_q + 3'd1;
        end else if (db_rise) begin
            // Empty characters are never separated.
            if (sym_cnt_q != 3'd0) begin
                if (units_q >= WORD_GAP) begin
                    space_d = 1'b1;
                end else if (units_q >= CHAR_GAP) begin
                    char_break_d = 1'b1;
                end else if (sym_cnt_q == SYM_MAX) begin
                    // Force a break so a character never exceeds five symbols.
                    char_break_d = 1'b1;
                end
                if (space_d || char_break_d) begin
                    sym_cnt_d = 3'd0;
                end
            end
        end else if (!key_db_q && word_open_q && (units_q == ETX_LIMIT)) begin
            etx_d       = 1'b1;
            word_open_d = 1'b0;
            sym_cnt_d   = 3'd0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sym_cnt_q       <= 3'd0;
            word_open_q     <= 1'b0;
            dot             <= 1'b0;
            dash            <= 1'b0;
            character_break <= 1'b0;
            space           <= 1'b0;
            etx             <= 1'b0;
        end else begin
            sym_cnt_q       <= sym_cnt_d;
            word_open_q     <= word_open_d;
            dot             <= dot_d;
            dash            <= dash_d;
            character_break <= char_break_d;
            space           <= space_d;
            etx             <= etx_d;
        end
    end

endmodule
